// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter
// Shares one tri-state bus among N tri-state buffer registers. Each requester
// asks to copy its register onto a destination register. The arbiter grants
// the bus round-robin. Each transfer runs in four phases: drive, settle,
// load, turnaround. At most one ENABLE bit is ever high, and the bus always
// sits idle for one cycle between two different drivers.
//
// Ports
//   CLOCK      rising-edge clock
//   CLEAR      synchronous active-high reset
//   REQ        REQ[i]=1: register i wants to drive the bus
//   DST        DST[i*IDXW +: IDXW] is the destination index for requester i
//   ENABLE     one-hot/zero, drives register i onto the bus
//   LOAD       one-hot/zero, captures the bus into register j
//   ACK        one-cycle pulse to the requester whose transfer completes
//   BUSY       high whenever the arbiter is not idle
//   GRANT_IDX  index of the current or most recent grant
module tri_bus_arbiter #(
    parameter int N      = 4,
    parameter int IDXW   = 2,
    parameter int SETTLE = 1
) (
    input  logic              CLOCK,
    input  logic              CLEAR,
    input  logic [N-1:0]      REQ,
    input  logic [N*IDXW-1:0] DST,
    output logic [N-1:0]      ENABLE,
    output logic [N-1:0]      LOAD,
    output logic [N-1:0]      ACK,
    output logic              BUSY,
    output logic [IDXW-1:0]   GRANT_IDX
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int SW = IDXW + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
    localparam logic [N-1:0]    ONE      = N'(1);

    typedef enum logic [1:0] {IDLE, DRIVE, XFER, TURN} state_t;

    state_t            state, next_state;
    logic [CW-1:0]     cnt, next_cnt;
    logic [IDXW-1:0]   grant, next_grant;
    logic [IDXW-1:0]   dst, next_dst;
    logic [IDXW-1:0]   ptr, next_ptr;
    logic [N-1:0]      next_enable, next_load, next_ack;
    logic [N-1:0]      req_masked;
    logic [IDXW-1:0]   dst_arr [N];
    logic              found;
    logic [IDXW-1:0]   win;
    logic [SW-1:0]     sum;
    logic [IDXW-1:0]   idx;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dst
            assign dst_arr[gi] = DST[gi*IDXW +: IDXW];
        end
    endgenerate

    // Round-robin search starting at the pointer. In TURN, the requester that
    // just finished is masked, so a REQ it still holds cannot win again at once.
    always_comb begin
        req_masked = REQ & ~((state == TURN) ? (ONE << grant) : '0);
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[IDXW-1:0];
            if (!found && req_masked[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state logic. Outputs are derived from the next state, so they can
    // be registered together with the state and match it cycle for cycle.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_grant = grant;
        next_dst   = dst;
        next_ptr   = ptr;
        case (state)
            IDLE, TURN: begin
                if (found) begin
                    next_state = DRIVE;
                    next_grant = win;
                    next_dst   = dst_arr[win];
                    next_cnt   = '0;
                end else begin
                    next_state = IDLE;
                end
            end
            DRIVE: begin
                if (cnt == CNT_LAST) begin
                    next_state = XFER;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            XFER: begin
                next_state = TURN;
                next_ptr   = (grant == LAST_IDX) ? '0 : grant + 1'b1;
            end
            default: next_state = IDLE;
        endcase

        next_enable = '0;
        next_load   = '0;
        next_ack    = '0;
        if (next_state == DRIVE || next_state == XFER) begin
            next_enable = ONE << next_grant;
        end
        if (next_state == XFER) begin
            next_ack = ONE << next_grant;
            // A destination index of N or more (possible when N is not a power of 2) loads nothing.
            if ({1'b0, next_dst} < SW'(N)) begin
                next_load = ONE << next_dst;
            end
        end
    end

    // State and output registers. CLEAR aborts any transfer, and the aborted transfer gets no ACK.
    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            state  <= IDLE;
            cnt    <= '0;
            grant  <= '0;
            dst    <= '0;
            ptr    <= '0;
            ENABLE <= '0;
            LOAD   <= '0;
            ACK    <= '0;
            BUSY   <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            grant  <= next_grant;
            dst    <= next_dst;
            ptr    <= next_ptr;
            ENABLE <= next_enable;
            LOAD   <= next_load;
            ACK    <= next_ack;
            BUSY   <= (next_state != IDLE);
        end
    end

    assign GRANT_IDX = grant;

endmodule
